// File: rtl/segway_pkg.sv
// Shared constants for the segway balance datapath: sensor offsets,
// complementary-filter fusion gains and the accelerometer pitch scale.
package segway_pkg;

    localparam logic [15:0] PTCH_RT_OFFSET_DEF = 16'h0050;
    localparam logic [15:0] AZ_OFFSET_DEF      = 16'h00A0;

    localparam int FUSE_FAST = 8192;
    localparam int FUSE_NORM = 1024;

    localparam logic signed [25:0] ACC_SCALE = 26'sd327;

    localparam int PTCH_INT_W = 27;

endpackage

// File: rtl/inertial_integrator.sv
// Pitch estimator: offset-compensates gyro rate and Z accel, integrates the
// rate into a 27-bit angle and pulls it toward the accelerometer pitch.
module inertial_integrator
    import segway_pkg::*;
#(
    parameter logic [15:0] PTCH_RT_OFFSET = PTCH_RT_OFFSET_DEF,
    parameter logic [15:0] AZ_OFFSET      = AZ_OFFSET_DEF,
    parameter int          FAST_SAMPLES   = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld,
    input  logic signed [15:0] ptch_rt,
    input  logic signed [15:0] AZ,
    output logic signed [15:0] ptch,
    output logic signed [15:0] ptch_rt_comp,
    output logic               ptch_vld
);

    localparam int CNT_W = (FAST_SAMPLES > 0) ? $clog2(FAST_SAMPLES + 1) : 1;
    localparam logic [CNT_W-1:0] FAST_MAX = CNT_W'(FAST_SAMPLES);

    logic signed [15:0]           rt_comp_q;
    logic signed [15:0]           az_comp_q;
    logic signed [PTCH_INT_W-1:0] ptch_int_q, ptch_int_d;
    logic [CNT_W-1:0]             fast_cnt_q, fast_cnt_d;
    logic                         upd_q;
    logic                         ptch_vld_q;

    logic signed [25:0] acc_prod;
    logic signed [15:0] ptch_acc;
    logic               fast_done;
    logic signed [27:0] gain;
    logic signed [27:0] fuse;
    logic signed [27:0] sum;

    // Top two bits of the 28-bit sum disagree only when it left the 27-bit range.
    function automatic logic signed [PTCH_INT_W-1:0] sat27(input logic signed [27:0] s);
        if (s[27] != s[26])
            return s[27] ? 27'h4000000 : 27'h3FFFFFF;
        return s[26:0];
    endfunction

    assign acc_prod = $signed({{10{az_comp_q[15]}}, az_comp_q}) * ACC_SCALE;
    assign ptch_acc = {{3{acc_prod[25]}}, acc_prod[25:13]};

    // Counter only ever climbs to FAST_MAX, so equality marks the end of fast mode.
    assign fast_done = (fast_cnt_q == FAST_MAX);
    assign gain      = fast_done ? 28'(FUSE_NORM) : 28'(FUSE_FAST);

    always_comb begin
        fuse = '0;
        if (ptch_acc > ptch)
            fuse = gain;
        else if (ptch_acc < ptch)
            fuse = -gain;
    end

    // Gyro sign convention: a positive rate reading decreases the pitch angle.
    assign sum = $signed({ptch_int_q[PTCH_INT_W-1], ptch_int_q})
               - $signed({{12{rt_comp_q[15]}}, rt_comp_q})
               + fuse;

    always_comb begin
        ptch_int_d = sat27(sum);
        fast_cnt_d = fast_done ? fast_cnt_q : fast_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rt_comp_q  <= '0;
            az_comp_q  <= '0;
            ptch_int_q <= '0;
            fast_cnt_q <= '0;
            upd_q      <= 1'b0;
            ptch_vld_q <= 1'b0;
        end else begin
            upd_q      <= vld;
            ptch_vld_q <= upd_q;
            if (vld) begin
                rt_comp_q <= ptch_rt - PTCH_RT_OFFSET;
                az_comp_q <= AZ - AZ_OFFSET;
            end
            if (upd_q) begin
                ptch_int_q <= ptch_int_d;
                fast_cnt_q <= fast_cnt_d;
            end
        end
    end

    assign ptch         = ptch_int_q[26:11];
    assign ptch_rt_comp = rt_comp_q;
    assign ptch_vld     = ptch_vld_q;

endmodule
